// File: rtl/data_memory_pkg.sv
// Shared encodings and helpers for the byte-addressable MIPS data memory.
package data_memory_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {CLEAR, IDLE} state_t;

  function automatic int addr_w(input int depth);
    return $clog2(depth) + 2;
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised RAM with per-byte write enables and a registered, enabled read port.
module byte_lane_ram #(
  parameter int DEPTH = 128,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic [IDX_W-1:0] addr,
  input  logic [3:0]       we,
  input  logic [31:0]      wdata,
  input  logic             re,
  output logic [31:0]      rdata
);

  logic [3:0][7:0] mem [DEPTH];

  // rdata only moves on a read so the last load result stays put between loads
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][i] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_be.sv
// Byte-addressable data memory: byte/half/word stores, extended loads,
// alignment rejection and an optional zero-fill sequence after reset.
module data_memory_be
  import data_memory_pkg::*;
#(
  parameter int DEPTH          = 128,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int ADDR_W         = addr_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              wren,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data,
  output logic [31:0]       q,
  output logic              q_valid,
  output logic              misaligned,
  output logic              busy
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] ln);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return ln[0];
      SZ_WORD: return ln != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] ln);
    case (sz)
      SZ_BYTE: return 4'b0001 << ln;
      SZ_HALF: return ln[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] steer(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz,
                                         input logic [1:0] ln, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (ln)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: return uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  state_t           state;
  logic [IDX_W-1:0] clr_cnt;

  logic             accept_p0, bad_p0, ld_p0, st_p0;
  logic [1:0]       lane_p0;
  logic [IDX_W-1:0] ram_addr;
  logic [3:0]       ram_we;
  logic [31:0]      ram_wdata;

  logic             loaded_p1;
  logic [1:0]       size_p1, lane_p1;
  logic             uns_p1;
  logic [31:0]      rdata_p1;

  // stage p0: request decode and RAM port steering
  assign lane_p0   = address[1:0];
  assign accept_p0 = req && (state == IDLE);
  assign bad_p0    = is_misaligned(size, lane_p0);
  assign ld_p0     = accept_p0 && !bad_p0 && !wren;
  assign st_p0     = accept_p0 && !bad_p0 && wren;

  always_comb begin
    ram_addr  = address[ADDR_W-1:2];
    ram_we    = 4'b0000;
    ram_wdata = steer(size, data);
    if (state == CLEAR) begin
      ram_addr  = clr_cnt;
      ram_we    = 4'b1111;
      ram_wdata = '0;
    end else if (st_p0) begin
      ram_we = lane_enables(size, lane_p0);
    end
  end

  byte_lane_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clock (clock),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .re    (ld_p0),
    .rdata (rdata_p1)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CLEAR_ON_RESET ? CLEAR : IDLE;
      busy       <= CLEAR_ON_RESET;
      clr_cnt    <= '0;
      q_valid    <= 1'b0;
      misaligned <= 1'b0;
      loaded_p1  <= 1'b0;
    end else begin
      q_valid    <= ld_p0;
      misaligned <= accept_p0 && bad_p0;
      if (ld_p0) loaded_p1 <= 1'b1;
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // stage p1: load attributes travel with the RAM read, held until the next load
  always_ff @(posedge clock) begin
    if (ld_p0) begin
      size_p1 <= size;
      lane_p1 <= lane_p0;
      uns_p1  <= unsigned_ld;
    end
  end

  assign q = loaded_p1 ? extend(rdata_p1, size_p1, lane_p1, uns_p1) : 32'd0;

endmodule

// File: tb/tb_data_memory_be.sv
// Directed scoreboard bench for data_memory_be (DEPTH=128, clear on reset).
module tb_data_memory_be;
  import data_memory_pkg::*;

  localparam int DEPTH = 128;
  localparam int AW    = addr_w(DEPTH);

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req = 1'b0, wren = 1'b0, unsigned_ld = 1'b0;
  logic [1:0]    size = 2'b00;
  logic [AW-1:0] address = '0;
  logic [31:0]   data = '0;
  logic [31:0]   q;
  logic          q_valid, misaligned, busy;

  data_memory_be #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .wren(wren), .size(size),
    .unsigned_ld(unsigned_ld), .address(address), .data(data),
    .q(q), .q_valid(q_valid), .misaligned(misaligned), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        vld;
    logic        mis;
    logic [31:0] q;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] q_m;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'd0;
    q_m = 32'd0;
    sb.delete();
  endtask

  // one request per call; expectation pushed at drive time, popped after the edge
  task automatic drive(input logic r, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic        bad;
    int          idx, ln;
    logic [31:0] wd;
    req = r; wren = w; size = sz; unsigned_ld = u; address = AW'(a); data = d;
    idx = int'(a[AW-1:2]);
    ln  = int'(a[1:0]);
    bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    e.vld = 1'b0;
    e.mis = 1'b0;
    if (r) begin
      if (bad) e.mis = 1'b1;
      else if (w) begin
        case (sz)
          2'b00:   mem_m[idx][8*ln +: 8]  = d[7:0];
          2'b01:   mem_m[idx][8*ln +: 16] = d[15:0];
          default: mem_m[idx]             = d;
        endcase
      end else begin
        wd = mem_m[idx] >> (8 * ln);
        case (sz)
          2'b00:   q_m = u ? {24'd0, wd[7:0]}  : {{24{wd[7]}}, wd[7:0]};
          2'b01:   q_m = u ? {16'd0, wd[15:0]} : {{16{wd[15]}}, wd[15:0]};
          default: q_m = mem_m[idx];
        endcase
        e.vld = 1'b1;
      end
    end
    e.q = q_m;
    sb.push_back(e);
    @(posedge clock); #1;
    req = 1'b0;
    e = sb.pop_front();
    check("q_valid", 32'(q_valid), 32'(e.vld));
    check("misaligned", 32'(misaligned), 32'(e.mis));
    check("q", q, e.q);
  endtask

  task automatic clear_wait(input bit stray);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      if (stray && n >= 90 && n < 96) begin
        req = 1'b1; wren = (n < 93); size = 2'b10; address = AW'(32'h14); data = 32'hdeadbeef;
      end else begin
        req = 1'b0;
      end
      @(posedge clock); #1;
      n++;
      check("clr_q_valid", 32'(q_valid), 32'd0);
      check("clr_misaligned", 32'(misaligned), 32'd0);
      check("clr_q", q, 32'd0);
    end
    req = 1'b0;
    check("busy_cycles", 32'(n), 32'd128);
  endtask

  task automatic reset_checks();
    check("rst_q", q, 32'd0);
    check("rst_q_valid", 32'(q_valid), 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    model_reset();
    #12;
    reset_checks();
    @(posedge clock); #1;
    reset_n = 1'b1;
    clear_wait(1'b1);

    drive(1, 0, 2'b10, 0, 32'h1fc, 0);  check("lw_1fc", q, 32'h00000000);
    drive(1, 0, 2'b10, 0, 32'h14, 0);   check("lw_stray", q, 32'h00000000);

    drive(1, 1, 2'b10, 0, 32'h10, 32'h8badf00d);
    drive(1, 0, 2'b10, 1, 32'h10, 0);   check("lw_10", q, 32'h8badf00d);
    drive(1, 0, 2'b00, 0, 32'h13, 0);   check("lb_13", q, 32'hffffff8b);
    drive(1, 0, 2'b00, 1, 32'h13, 0);   check("lbu_13", q, 32'h0000008b);
    drive(1, 0, 2'b01, 0, 32'h12, 0);   check("lh_12", q, 32'hffff8bad);
    drive(1, 0, 2'b01, 1, 32'h10, 0);   check("lhu_10", q, 32'h0000f00d);

    drive(1, 1, 2'b00, 0, 32'h11, 32'h000000aa);
    drive(1, 0, 2'b10, 0, 32'h10, 0);   check("raw_sb", q, 32'h8badaa0d);
    drive(1, 1, 2'b01, 0, 32'h12, 32'h00001234);
    drive(1, 0, 2'b01, 0, 32'h12, 0);   check("raw_sh", q, 32'h00001234);

    drive(1, 1, 2'b10, 0, 32'h20, 32'h12345678);
    drive(1, 0, 2'b10, 0, 32'h20, 0);
    drive(1, 1, 2'b01, 0, 32'h21, 32'h0000ffff);
    drive(1, 1, 2'b10, 0, 32'h22, 32'h00000000);
    drive(1, 1, 2'b11, 0, 32'h20, 32'hcafebabe);
    drive(1, 0, 2'b01, 0, 32'h23, 0);   check("mis_q_held", q, 32'h12345678);
    drive(0, 0, 2'b00, 0, 32'h0, 0);
    drive(1, 0, 2'b10, 0, 32'h20, 0);   check("mis_unchanged", q, 32'h12345678);

    drive(1, 1, 2'b10, 0, 32'h40, 32'h11111111);
    drive(1, 1, 2'b10, 0, 32'h44, 32'h22222222);
    drive(1, 1, 2'b10, 0, 32'h48, 32'h33333333);
    drive(1, 1, 2'b10, 0, 32'h4c, 32'h44444444);
    drive(1, 0, 2'b10, 0, 32'h40, 0);   check("b2b_0", q, 32'h11111111);
    drive(1, 0, 2'b10, 0, 32'h44, 0);   check("b2b_1", q, 32'h22222222);
    drive(1, 0, 2'b10, 0, 32'h48, 0);   check("b2b_2", q, 32'h33333333);
    drive(1, 0, 2'b10, 0, 32'h4c, 0);   check("b2b_3", q, 32'h44444444);
    drive(0, 0, 2'b00, 0, 32'h0, 0);

    reset_n = 1'b0;
    #2;
    reset_checks();
    model_reset();
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (50) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #2;
    check("midclr_busy", 32'(busy), 32'd1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    clear_wait(1'b0);
    drive(1, 0, 2'b10, 0, 32'h10, 0);   check("post_clear", q, 32'h00000000);
    drive(1, 0, 2'b10, 0, 32'h4c, 0);   check("post_clear_4c", q, 32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
